mlblock_config_loader: RTL

- Upstream feeder for the MLBlock serial configuration chain.
- Accepts one parallel configuration word per load through a valid/ready handshake.
- Serialises the word MSB-first onto config_in, with config_en held for exactly CHAIN_LEN cycles. After that, chain position p holds cfg_word[p].
- Sits between the host/CSR logic and the config_in/config_en/config_out pins of one MLBlock, or of a daisy-chain of MLBlocks.

---
 rtl/mlblock_cfg_pkg.sv | 16 +
 rtl/mlblock_cfg_piso.sv | 32 +++
 rtl/mlblock_config_loader.sv | 63 ++++++
 3 files changed

// File: rtl/mlblock_cfg_pkg.sv
// mlblock_cfg_pkg: shared FSM state type, counter sizing and per-variant chain lengths for the MLBlock config loader.
package mlblock_cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int I_D_HALF = 6;
  localparam int RES_D_CNTL = 2;
  localparam int MAC_CFG_BITS = 8;
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction
  function automatic int block_chain_len(input int n_blocks, input int n_macs);
    return n_blocks * (I_D_HALF + RES_D_CNTL + n_macs * MAC_CFG_BITS);
  endfunction
  localparam int CHAIN_LEN_1MAC = block_chain_len(1, 1);
  localparam int CHAIN_LEN_2MAC = block_chain_len(1, 2);
  localparam int CHAIN_LEN_4MAC = block_chain_len(1, 4);
endpackage

// File: rtl/mlblock_cfg_piso.sv
// mlblock_cfg_piso: parallel-in/serial-out shift register with optional readback capture (CONFIG_READBACK_EN).
module mlblock_cfg_piso #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N-1:0] word_i,
  input  logic         ser_i,
  output logic         msb_o,
  output logic [N-1:0] rb_o
);
  logic [N-1:0] sreg_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sreg_q <= '0;
    else if (load_i) sreg_q <= word_i;
    else if (shift_i) sreg_q <= {sreg_q[N-2:0], 1'b0};
  assign msb_o = sreg_q[N-1];
`ifdef CONFIG_READBACK_EN
  logic [N-1:0] rb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) rb_q <= '0;
    else if (load_i) rb_q <= '0;
    else if (shift_i) rb_q <= {rb_q[N-2:0], ser_i};
  assign rb_o = rb_q;
`else
  logic unused_ser;
  assign unused_ser = ser_i;
  assign rb_o = '0;
`endif
endmodule

// File: rtl/mlblock_config_loader.sv
// mlblock_config_loader: feeds one parallel word MSB-first into the MLBlock serial config chain.
// Define CONFIG_READBACK_EN to capture the chain's previous contents from config_out into rb_word.
module mlblock_config_loader
  import mlblock_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_1MAC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_word,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 config_en,
  output logic                 config_in,
  input  logic                 config_out,
  output logic [CHAIN_LEN-1:0] rb_word
);
  localparam int CNT_W = cnt_width(CHAIN_LEN);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, last, msb;
  assign accept = (state_q == IDLE) && cfg_valid;
  assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: state_d = cfg_valid ? SHIFT : IDLE;
      SHIFT: begin
        state_d = abort ? IDLE : last ? DONE : SHIFT;
        cnt_d = (abort || last) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs come only from registered state so the chain never sees input glitches.
  assign cfg_ready = state_q == IDLE;
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign config_en = busy;
  assign config_in = busy & msb;
  mlblock_cfg_piso #(.N(CHAIN_LEN)) u_piso (
    .clk    (clk),
    .rst    (reset),
    .load_i (accept),
    .shift_i(busy),
    .word_i (cfg_word),
    .ser_i  (config_out),
    .msb_o  (msb),
    .rb_o   (rb_word)
  );
endmodule
